// File: rtl/crc_stream_param_if.sv
// -----------------------------------------------------------------------------
// crc_stream_param_if
// Bundles the input data stream and the result port of crc_stream_param.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge when
// valid && ready are both high. The source holds its payload stable while
// valid is high and ready is low. Valid never waits on ready.
//
// Signals:
//   s_valid/s_ready/s_data/s_keep/s_last : data stream into the CRC engine
//   m_valid/m_ready/m_crc/m_match/m_bytes: per-frame result out of the engine
//
// Modports:
//   master : stream producer / result consumer (upstream logic, testbench)
//   slave  : the CRC engine itself
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface crc_stream_param_if #(
  parameter int DATA_W = 32,
  parameter int CRC_W  = 32
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_W-1:0]     s_data;
  logic [DATA_W/8-1:0]   s_keep;
  logic                  s_last;
  logic                  m_valid;
  logic                  m_ready;
  logic [CRC_W-1:0]      m_crc;
  logic                  m_match;
  logic [15:0]           m_bytes;

  modport master (
    output s_valid, s_data, s_keep, s_last, m_ready,
    input  s_ready, m_valid, m_crc, m_match, m_bytes
  );

  modport slave (
    input  s_valid, s_data, s_keep, s_last, m_ready,
    output s_ready, m_valid, m_crc, m_match, m_bytes
  );
endinterface

// File: rtl/crc_stream_param.sv
// -----------------------------------------------------------------------------
// crc_stream_param
// Parametrised frame-oriented CRC engine. Consumes a byte-keyed data stream,
// folds a full beat into the CRC register each cycle, and after the last beat
// presents the frame CRC, byte count and residue-match flag on the result port.
//
// Ports:
//   clk       : clock
//   rst_n     : asynchronous active-low reset
//   s_clr     : synchronous abort; drops the current frame and pending result
//   bus       : crc_stream_param_if.slave (stream in, result out)
//   dbg_state : current FSM state (0 = ACC, 1 = RES)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module crc_stream_param #(
  parameter int          DATA_W  = 32,
  parameter int          CRC_W   = 32,
  parameter logic [31:0] POLY    = 32'h04C11DB7,
  parameter logic [31:0] INIT    = 32'hFFFFFFFF,
  parameter bit          REFIN   = 1'b1,
  parameter bit          REFOUT  = 1'b1,
  parameter logic [31:0] XOROUT  = 32'hFFFFFFFF,
  parameter logic [31:0] RESIDUE = 32'hC704DD7B
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_clr,
  crc_stream_param_if.slave  bus,
  output logic [0:0]         dbg_state
);

  localparam int NB = DATA_W / 8;

  // ACC: accepting beats of a frame; RES: holding the result for the consumer.
  localparam logic [0:0] ST_ACC = 1'b0;
  localparam logic [0:0] ST_RES = 1'b1;

  localparam logic [CRC_W-1:0] POLY_W    = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] INIT_W    = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] XOROUT_W  = XOROUT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] RESIDUE_W = RESIDUE[CRC_W-1:0];

  logic [0:0]       state_q;
  logic [CRC_W-1:0] crc_q;
  logic [15:0]      cnt_q;

  logic             m_valid_q;
  logic [CRC_W-1:0] m_crc_q;
  logic             m_match_q;
  logic [15:0]      m_bytes_q;

  logic [CRC_W-1:0] crc_next;
  logic [CRC_W-1:0] crc_out;
  logic [3:0]       nbytes;
  logic [16:0]      cnt_sum;
  logic [15:0]      cnt_next;
  logic             fb;

  function automatic logic [CRC_W-1:0] bitrev(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    r = '0;
    for (int i = 0; i < CRC_W; i++) begin
      r[i] = v[CRC_W-1-i];
    end
    return r;
  endfunction

  // Whole-beat CRC update: bytes 0..NB-1 in order, each byte serialised
  // LSB-first when REFIN, MSB-first otherwise. On a non-last beat every byte
  // counts; on the last beat only kept bytes (keep is contiguous from bit 0).
  always_comb begin
    crc_next = crc_q;
    nbytes   = '0;
    fb       = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (!bus.s_last || bus.s_keep[i]) begin
        for (int j = 0; j < 8; j++) begin
          fb = crc_next[CRC_W-1] ^
               (REFIN ? bus.s_data[8*i+j] : bus.s_data[8*i+7-j]);
          crc_next = {crc_next[CRC_W-2:0], 1'b0} ^
                     (fb ? POLY_W : {CRC_W{1'b0}});
        end
        nbytes = nbytes + 4'd1;
      end
    end
    // The counter saturates; the CRC itself keeps running for any length.
    cnt_sum  = {1'b0, cnt_q} + {13'd0, nbytes};
    cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    crc_out  = (REFOUT ? bitrev(crc_next) : crc_next) ^ XOROUT_W;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ACC;
      crc_q     <= INIT_W;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_crc_q   <= '0;
      m_match_q <= 1'b0;
      m_bytes_q <= '0;
    end else if (s_clr) begin
      // Abort wins over any beat or handshake in the same cycle.
      state_q   <= ST_ACC;
      crc_q     <= INIT_W;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (bus.s_valid) begin
            if (bus.s_last) begin
              // Result captured from the post-beat values; the register is
              // reloaded in the same edge so the next frame starts clean.
              state_q   <= ST_RES;
              m_valid_q <= 1'b1;
              m_crc_q   <= crc_out;
              m_match_q <= (crc_next == RESIDUE_W);
              m_bytes_q <= cnt_next;
              crc_q     <= INIT_W;
              cnt_q     <= '0;
            end else begin
              crc_q <= crc_next;
              cnt_q <= cnt_next;
            end
          end
        end
        ST_RES: begin
          if (bus.m_ready) begin
            state_q   <= ST_ACC;
            m_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_ACC;
        end
      endcase
    end
  end

  // s_ready is a pure decode of the state register, so a result handshake
  // only re-opens the input on the following cycle.
  assign bus.s_ready = (state_q == ST_ACC);
  assign bus.m_valid = m_valid_q;
  assign bus.m_crc   = m_crc_q;
  assign bus.m_match = m_match_q;
  assign bus.m_bytes = m_bytes_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_crc_stream_param.sv
// -----------------------------------------------------------------------------
// tb_crc_stream_param
// Directed bench for crc_stream_param: a CRC-32 / 32-bit instance driven from a
// vector table plus hand-written corner sequences, and a CRC-16/CCITT-FALSE
// 8-bit instance.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_crc_stream_param;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr32;
  logic       clr8;
  logic [0:0] st32;
  logic [0:0] st8;

  always #5 clk = ~clk;

  crc_stream_param_if #(.DATA_W(32), .CRC_W(32)) b32 ();
  crc_stream_param_if #(.DATA_W(8),  .CRC_W(16)) b8 ();

  crc_stream_param u_crc32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_clr     (clr32),
    .bus       (b32.slave),
    .dbg_state (st32)
  );

  crc_stream_param #(
    .DATA_W  (8),
    .CRC_W   (16),
    .POLY    (32'h00001021),
    .INIT    (32'h0000FFFF),
    .REFIN   (1'b0),
    .REFOUT  (1'b0),
    .XOROUT  (32'h00000000),
    .RESIDUE (32'h00000000)
  ) u_crc16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_clr     (clr8),
    .bus       (b8.slave),
    .dbg_state (st8)
  );

  // ---------------- scoreboard ----------------
  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  typedef struct {
    string           name;
    logic [3:0][31:0] beats;
    int              nbeats;
    logic [3:0]      keep;
    logic [31:0]     crc;
    logic [15:0]     bytes;
    logic            match;
  } vec_t;

  vec_t vecs[5];

  // ---------------- driver tasks (32-bit instance) ----------------
  task automatic beat32(input logic [31:0] d, input logic [3:0] k, input logic l);
    @(negedge clk);
    b32.s_valid = 1'b1;
    b32.s_data  = d;
    b32.s_keep  = k;
    b32.s_last  = l;
    @(posedge clk);
  endtask

  task automatic end32();
    @(negedge clk);
    b32.s_valid = 1'b0;
    b32.s_last  = 1'b0;
    b32.s_keep  = '0;
    b32.s_data  = '0;
  endtask

  // Non-last beats carry keep = 0 to show keep is ignored there.
  task automatic frame32(input int idx);
    for (int b = 0; b < vecs[idx].nbeats; b++) begin
      if (b == vecs[idx].nbeats - 1) beat32(vecs[idx].beats[b], vecs[idx].keep, 1'b1);
      else                           beat32(vecs[idx].beats[b], 4'b0000, 1'b0);
    end
    end32();
  endtask

  // Called at the negedge one cycle after the last-beat edge.
  task automatic check_res32(input string nm, input int idx);
    logic [31:0] e;
    e = exp_q.pop_front();
    check({nm, " m_valid"}, {31'd0, b32.m_valid}, 32'd1);
    check({nm, " m_crc"},   b32.m_crc, e);
    check({nm, " m_bytes"}, {16'd0, b32.m_bytes}, {16'd0, vecs[idx].bytes});
    check({nm, " m_match"}, {31'd0, b32.m_match}, {31'd0, vecs[idx].match});
  endtask

  task automatic ack32(input string nm);
    b32.m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b32.m_ready = 1'b0;
    check({nm, " ack m_valid"}, {31'd0, b32.m_valid}, 32'd0);
    check({nm, " ack s_ready"}, {31'd0, b32.s_ready}, 32'd1);
  endtask

  task automatic beat8(input logic [7:0] d, input logic l);
    @(negedge clk);
    b8.s_valid = 1'b1;
    b8.s_data  = d;
    b8.s_keep  = 1'b1;
    b8.s_last  = l;
    @(posedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{name: "crc32_123456789", beats: {32'h0, 32'h00000039, 32'h38373635, 32'h34333231},
                nbeats: 3, keep: 4'b0001, crc: 32'hCBF43926, bytes: 16'd9,  match: 1'b0};
    vecs[1] = '{name: "crc32_with_fcs",  beats: {32'h000000CB, 32'hF4392639, 32'h38373635, 32'h34333231},
                nbeats: 4, keep: 4'b0001, crc: 32'h2144DF1C, bytes: 16'd13, match: 1'b1};
    vecs[2] = '{name: "crc32_empty",     beats: {32'h0, 32'h0, 32'h0, 32'hDEADBEEF},
                nbeats: 1, keep: 4'b0000, crc: 32'h00000000, bytes: 16'd0,  match: 1'b0};
    vecs[3] = '{name: "crc32_a",         beats: {32'h0, 32'h0, 32'h0, 32'hAABBCC61},
                nbeats: 1, keep: 4'b0001, crc: 32'hE8B7BE43, bytes: 16'd1,  match: 1'b0};
    vecs[4] = '{name: "crc32_abc",       beats: {32'h0, 32'h0, 32'h0, 32'hFF636261},
                nbeats: 1, keep: 4'b0111, crc: 32'h352441C2, bytes: 16'd3,  match: 1'b0};

    rst_n = 1'b0;
    clr32 = 1'b0;
    clr8  = 1'b0;
    b32.s_valid = 1'b0; b32.s_data = '0; b32.s_keep = '0; b32.s_last = 1'b0; b32.m_ready = 1'b0;
    b8.s_valid  = 1'b0; b8.s_data  = '0; b8.s_keep  = '0; b8.s_last  = 1'b0; b8.m_ready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("reset m_valid", {31'd0, b32.m_valid}, 32'd0);
    check("reset s_ready", {31'd0, b32.s_ready}, 32'd1);
    check("reset m_crc",   b32.m_crc, 32'd0);
    check("reset m_bytes", {16'd0, b32.m_bytes}, 32'd0);
    check("reset m_match", {31'd0, b32.m_match}, 32'd0);
    check("reset state",   {31'd0, st32}, 32'd0);

    // Table-driven frames
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(vecs[i].crc);
      frame32(i);
      check_res32(vecs[i].name, i);
      ack32(vecs[i].name);
    end

    // Stall the result consumer for 5 cycles while offering a junk beat
    exp_q.push_back(vecs[0].crc);
    frame32(0);
    check_res32("hold", 0);
    b32.s_valid = 1'b1; b32.s_data = 32'h5A5A5A5A; b32.s_keep = 4'b1111; b32.s_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("hold%0d m_valid", c), {31'd0, b32.m_valid}, 32'd1);
      check($sformatf("hold%0d m_crc", c),   b32.m_crc, 32'hCBF43926);
      check($sformatf("hold%0d m_bytes", c), {16'd0, b32.m_bytes}, 32'd9);
      check($sformatf("hold%0d s_ready", c), {31'd0, b32.s_ready}, 32'd0);
    end
    ack32("hold");
    b32.s_valid = 1'b0; b32.s_last = 1'b0; b32.s_keep = '0;

    // Back-to-back frame after the stall: INIT must have been reloaded
    exp_q.push_back(vecs[0].crc);
    frame32(0);
    check_res32("b2b", 0);
    ack32("b2b");

    // Abort during beat 2 of a 3-beat frame, then the full frame
    beat32(32'h34333231, 4'b0000, 1'b0);
    @(negedge clk);
    clr32 = 1'b1;
    b32.s_valid = 1'b1; b32.s_data = 32'h38373635; b32.s_keep = 4'b0000; b32.s_last = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clr32 = 1'b0;
    b32.s_valid = 1'b0;
    exp_q.push_back(vecs[0].crc);
    frame32(0);
    check_res32("clr_mid", 0);
    ack32("clr_mid");

    // Abort while a result is pending
    exp_q.push_back(vecs[3].crc);
    frame32(3);
    check_res32("clr_res", 3);
    clr32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr32 = 1'b0;
    check("clr_res m_valid", {31'd0, b32.m_valid}, 32'd0);
    check("clr_res s_ready", {31'd0, b32.s_ready}, 32'd1);

    // Asynchronous reset while in RES
    exp_q.push_back(vecs[4].crc);
    frame32(4);
    check_res32("rst_res", 4);
    rst_n = 1'b0;
    #1;
    check("rst_res m_valid", {31'd0, b32.m_valid}, 32'd0);
    check("rst_res s_ready", {31'd0, b32.s_ready}, 32'd1);
    check("rst_res state",   {31'd0, st32}, 32'd0);
    #2;
    rst_n = 1'b1;
    exp_q.push_back(vecs[0].crc);
    frame32(0);
    check_res32("after_rst", 0);
    ack32("after_rst");

    // Byte counter saturation: 16384 full beats + empty last = 65536 bytes
    for (int b = 0; b < 16384; b++) beat32(32'h0, 4'b0000, 1'b0);
    beat32(32'h0, 4'b0000, 1'b1);
    end32();
    check("sat m_valid", {31'd0, b32.m_valid}, 32'd1);
    check("sat m_bytes", {16'd0, b32.m_bytes}, 32'h0000FFFF);
    ack32("sat");

    // CRC-16/CCITT-FALSE on the 8-bit instance
    for (int i = 0; i < 9; i++) beat8(8'h31 + 8'(i), (i == 8));
    @(negedge clk);
    b8.s_valid = 1'b0; b8.s_last = 1'b0;
    check("crc16 m_valid", {31'd0, b8.m_valid}, 32'd1);
    check("crc16 m_crc",   {16'd0, b8.m_crc}, 32'h000029B1);
    check("crc16 m_bytes", {16'd0, b8.m_bytes}, 32'd9);
    check("crc16 s_ready", {31'd0, b8.s_ready}, 32'd0);
    b8.m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b8.m_ready = 1'b0;
    check("crc16 ack m_valid", {31'd0, b8.m_valid}, 32'd0);
    check("crc16 ack s_ready", {31'd0, b8.s_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/crc_stream_param.md
Name: crc_stream_param

Overview:
- Parametrised, frame-oriented CRC engine; successor to the fixed 32-bit, always-enabled CRC-32 LFSR block.
- Accepts a valid/ready data stream with byte keep and last-beat marking.
- Runs any CRC up to 32 bits, with configurable init, input/output reflection and final XOR.
- After the last beat it emits the frame CRC, the frame byte count and a residue-match flag on a valid/ready result port.
- Used on both TX (FCS generation) and RX (FCS check) sides of the framing datapath.

Parameters:
- DATA_W, 32, stream width in bits; multiple of 8, range 8..64.
- CRC_W, 32, CRC width in bits; range 8..32.
- POLY, 32'h04C11DB7, generator polynomial, normal form (x^CRC_W term implied), low CRC_W bits used.
- INIT, 32'hFFFFFFFF, register value at start of every frame.
- REFIN, 1, 1 = each byte fed LSB first, 0 = MSB first.
- REFOUT, 1, 1 = bit-reverse the register before the final XOR.
- XOROUT, 32'hFFFFFFFF, final XOR applied to m_crc.
- RESIDUE, 32'hC704DD7B, register value (pre-REFOUT/XOROUT) that signals a good frame when the FCS is included.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_clr  in  1  synchronous abort: discard current frame and any pending result.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  DATA_W  input data; byte 0 = s_data[7:0] is processed first.
- s_keep  in  DATA_W/8  byte enables, contiguous from bit 0; honoured on the last beat only.
- s_last  in  1  final beat of the frame.
- m_valid  out  1  result valid.
- m_ready  in  1  result accepted when m_valid && m_ready.
- m_crc  out  CRC_W  final CRC after REFOUT and XOROUT.
- m_match  out  1  1 when the pre-output register equals RESIDUE[CRC_W-1:0].
- m_bytes  out  16  bytes in the frame; saturates at 16'hFFFF.

Behaviour:
- Reset (rst_n low, asynchronous): state ACC, register = INIT, byte counter = 0, m_valid = 0, m_crc = 0, m_match = 0, m_bytes = 0, s_ready = 1.
- Bit model, per input bit b:
  - fb = reg[CRC_W-1] ^ b;
  - reg = (reg << 1) ^ (fb ? POLY : 0), truncated to CRC_W bits.
- Byte ordering: bytes are processed 0..N-1 within a beat; bit order inside each byte is set by REFIN. The whole beat is one combinational update per cycle.
- Non-last beats: s_keep is ignored and treated as all ones.
- Last beat: only kept bytes are processed. s_keep = 0 on the last beat is legal and adds no bytes. Non-contiguous keep is undefined and not checked.
- State ACC:
  - s_ready = 1.
  - Accepted beat: reg updated, counter += kept bytes, with saturation.
  - Accepted beat with s_last: next state RES. In the same edge, m_crc/m_match/m_bytes are loaded from the post-beat values and m_valid is set. Latency is 1 cycle from the last-beat edge to m_valid.
  - On that edge reg reloads INIT and the counter clears.
- State RES:
  - s_ready = 0.
  - m_valid, m_crc, m_match and m_bytes are held stable until m_valid && m_ready.
  - Next state ACC on handshake; s_ready returns 1 the following cycle, with no same-cycle pass-through.
- m_crc = (REFOUT ? bitrev(reg) : reg) ^ XOROUT[CRC_W-1:0].
- s_clr (either state) has priority over all stream activity:
  - next state ACC, reg = INIT, counter = 0, m_valid = 0;
  - any beat presented in the same cycle is dropped.
- Counter saturation only affects m_bytes; the CRC continues correctly for frames of any length.
- Reset asserted mid-frame or mid-result: all state is lost and the next frame starts clean.
- All outputs are registered; none is combinational from an input.

Test Plan:
- CRC-32 defaults, DATA_W=32, "123456789": beats 32'h34333231, 32'h38373635, then 32'h00000039 with keep=4'b0001 and last -> m_valid one cycle after the last beat, m_crc=32'hCBF43926, m_bytes=9, m_match=0.
- Same 9 bytes followed by FCS bytes 26 39 F4 CB (13 bytes, last keep=4'b0001) -> m_match=1, m_crc=32'h2144DF1C, m_bytes=13.
- Hold m_ready=0 for 5 cycles after the result -> m_valid/m_crc/m_bytes stable and s_ready=0 throughout. Pulse m_ready=1 -> m_valid drops and s_ready=1 the next cycle. A back-to-back second frame gives the correct CRC, proving INIT reload.
- DATA_W=8, CRC_W=16, POLY=16'h1021, INIT=16'hFFFF, REFIN=0, REFOUT=0, XOROUT=0, "123456789" -> m_crc=16'h29B1, m_bytes=9.
- CRC-32 single beat, keep=0, last (empty frame) -> m_crc=32'h00000000, m_bytes=0.
- Abort and reset recovery:
  - s_clr during beat 2 of a 3-beat frame, then the full "123456789" frame -> m_crc=32'hCBF43926.
  - rst_n pulse low while in RES -> m_valid=0 immediately, s_ready=1.
